// File: rtl/lever_pkg.sv
// Shared types and helpers for the lever-and-platform controller.
//   pos_width(n)  : bits needed to hold an index in [0, n-1], never below 1
//   plat_off_t    : platform displacement in pixels (10 bits)
//   PLAT_STEP_PX  : pixels the platform travels per frame tick
package lever_pkg;

    typedef logic [9:0] plat_off_t;

    localparam int PLAT_STEP_PX = 1;

    function automatic int pos_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/push_edge_det.sv
// Per-bit rising-edge detector for push request levels.
// Ports:
//   Clk    in   system clock
//   Reset  in   asynchronous active-high reset (clears history)
//   level  in   W request levels
//   rise   out  W one-cycle event flags (level high, history low)
module push_edge_det #(
    parameter int W = 2
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] history_reg;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    history_reg[gi] <= 1'b0;
                end else begin
                    history_reg[gi] <= level[gi];
                end
            end

            // History clears to 0, so a level high on the first cycle
            // after reset counts as a fresh press.
            assign rise[gi] = level[gi] & ~history_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/lever_platform_ctrl.sv
// N-position lever pushed by several players, driving a sliding platform.
// Ports:
//   Clk           in   system clock
//   Reset         in   asynchronous active-high reset
//   frame_tick    in   one-cycle pulse per video frame
//   push_left     in   NUM_PLAYERS levels, request index +1
//   push_right    in   NUM_PLAYERS levels, request index -1
//   lever_pos     out  current lever index (0 = rightmost)
//   lever_onehot  out  one-hot decode of lever_pos
//   end_stop      out  per player: pushing against an end stop
//   plat_offset   out  platform displacement in pixels
//   plat_moving   out  platform not yet at its target
//   plat_down     out  lever fully left and platform settled
module lever_platform_ctrl
    import lever_pkg::*;
#(
    parameter int NUM_POS        = 3,
    parameter int NUM_PLAYERS    = 2,
    parameter int COOLDOWN       = 8,
    parameter int TRAVEL_PER_POS = 24,
    localparam int POS_W         = pos_width(NUM_POS)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_tick,
    input  logic [NUM_PLAYERS-1:0] push_left,
    input  logic [NUM_PLAYERS-1:0] push_right,
    output logic [POS_W-1:0]       lever_pos,
    output logic [NUM_POS-1:0]     lever_onehot,
    output logic [NUM_PLAYERS-1:0] end_stop,
    output logic [9:0]             plat_offset,
    output logic                   plat_moving,
    output logic                   plat_down
);

    localparam int CD_W = pos_width(COOLDOWN + 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_POS - 1);

    logic [NUM_PLAYERS-1:0] left_rise;
    logic [NUM_PLAYERS-1:0] right_rise;

    logic [POS_W-1:0]       lever_pos_reg;
    logic [CD_W-1:0]        cooldown_reg;
    logic [NUM_PLAYERS-1:0] end_stop_reg;
    logic [NUM_PLAYERS-1:0] end_stop_next;
    plat_off_t              plat_offset_reg;
    plat_off_t              target;

    logic step_up;
    logic step_dn;
    logic accept_up;
    logic accept_dn;
    logic cooldown_idle;

    push_edge_det #(.W(NUM_PLAYERS)) u_left_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .level (push_left),
        .rise  (left_rise)
    );

    push_edge_det #(.W(NUM_PLAYERS)) u_right_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .level (push_right),
        .rise  (right_rise)
    );

    // Opposing events in the same cycle cancel each other out.
    assign step_up       = (|left_rise) & ~(|right_rise);
    assign step_dn       = (|right_rise) & ~(|left_rise);
    assign cooldown_idle = (cooldown_reg == '0);
    assign accept_up     = step_up & cooldown_idle & (lever_pos_reg != POS_MAX);
    assign accept_dn     = step_dn & cooldown_idle & (lever_pos_reg != '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lever_pos_reg <= '0;
            cooldown_reg  <= '0;
        end else begin
            if (accept_up) begin
                lever_pos_reg <= lever_pos_reg + POS_W'(1);
            end else if (accept_dn) begin
                lever_pos_reg <= lever_pos_reg - POS_W'(1);
            end

            // A fresh load wins over a coincident frame decrement.
            if (accept_up || accept_dn) begin
                cooldown_reg <= CD_W'(COOLDOWN);
            end else if (frame_tick && !cooldown_idle) begin
                cooldown_reg <= cooldown_reg - CD_W'(1);
            end
        end
    end

    // End stops are pure level checks against the current index; the
    // cooldown does not affect them.
    generate
        for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_stop
            assign end_stop_next[gi] = (push_left[gi]  && (lever_pos_reg == POS_MAX)) ||
                                       (push_right[gi] && (lever_pos_reg == '0));
        end
    endgenerate

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            end_stop_reg <= '0;
        end else begin
            end_stop_reg <= end_stop_next;
        end
    end

    // Target follows the registered lever index, so a tick coinciding with
    // a lever move still steps toward the old target.
    assign target = plat_off_t'(int'(lever_pos_reg) * TRAVEL_PER_POS);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            plat_offset_reg <= '0;
        end else if (frame_tick) begin
            if (plat_offset_reg < target) begin
                plat_offset_reg <= plat_offset_reg + plat_off_t'(PLAT_STEP_PX);
            end else if (plat_offset_reg > target) begin
                plat_offset_reg <= plat_offset_reg - plat_off_t'(PLAT_STEP_PX);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_POS; gi++) begin : g_onehot
            assign lever_onehot[gi] = (lever_pos_reg == POS_W'(gi));
        end
    endgenerate

    assign lever_pos   = lever_pos_reg;
    assign end_stop    = end_stop_reg;
    assign plat_offset = plat_offset_reg;
    assign plat_moving = (plat_offset_reg != target);
    assign plat_down   = (lever_pos_reg == POS_MAX) && (plat_offset_reg == target);

endmodule

// File: tb/tb_lever_platform_ctrl.sv
module tb_lever_platform_ctrl;

    localparam int NP   = 3;
    localparam int NPL  = 2;
    localparam int CD   = 8;
    localparam int TRV  = 24;

    logic           Clk;
    logic           Reset;
    logic           frame_tick;
    logic [NPL-1:0] push_left;
    logic [NPL-1:0] push_right;
    logic [1:0]     lever_pos;
    logic [NP-1:0]  lever_onehot;
    logic [NPL-1:0] end_stop;
    logic [9:0]     plat_offset;
    logic           plat_moving;
    logic           plat_down;

    lever_platform_ctrl #(
        .NUM_POS(NP), .NUM_PLAYERS(NPL), .COOLDOWN(CD), .TRAVEL_PER_POS(TRV)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .push_left    (push_left),
        .push_right   (push_right),
        .lever_pos    (lever_pos),
        .lever_onehot (lever_onehot),
        .end_stop     (end_stop),
        .plat_offset  (plat_offset),
        .plat_moving  (plat_moving),
        .plat_down    (plat_down)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int pos;
        int oh;
        int es;
        int off;
        int mov;
        int dn;
    } exp_t;

    exp_t exp_q[$];

    int tests_run;
    int tests_failed;

    // Reference state
    int m_pos;
    int m_cd;
    int m_off;
    int m_es;
    int m_prev_l;
    int m_prev_r;

    task automatic chk(input string tag, input int obs, input int expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_cd = 0; m_off = 0; m_es = 0; m_prev_l = 0; m_prev_r = 0;
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, then
    // compare once the edge has happened.
    task automatic cycle(input bit tick, input int pl, input int pr);
        int ev_l, ev_r, step, tgt, pos_n, cd_n, off_n, es_n, tgt_n;
        bit acc;
        exp_t e, got;
        frame_tick = tick;
        push_left  = pl[NPL-1:0];
        push_right = pr[NPL-1:0];

        ev_l = pl & ~m_prev_l & 3;
        ev_r = pr & ~m_prev_r & 3;
        step = 0;
        if (ev_l != 0 && ev_r == 0) step = 1;
        if (ev_r != 0 && ev_l == 0) step = -1;
        acc = (step != 0) && (m_cd == 0) && (m_pos + step >= 0) && (m_pos + step <= NP - 1);

        tgt = m_pos * TRV;
        off_n = m_off;
        if (tick) begin
            if (m_off < tgt) off_n = m_off + 1;
            else if (m_off > tgt) off_n = m_off - 1;
        end
        pos_n = acc ? m_pos + step : m_pos;
        if (acc) cd_n = CD;
        else if (tick && m_cd > 0) cd_n = m_cd - 1;
        else cd_n = m_cd;
        es_n = 0;
        for (int i = 0; i < NPL; i++) begin
            if ((pl[i] && m_pos == NP - 1) || (pr[i] && m_pos == 0)) es_n |= (1 << i);
        end

        m_pos = pos_n; m_cd = cd_n; m_off = off_n; m_es = es_n;
        m_prev_l = pl; m_prev_r = pr;

        tgt_n = pos_n * TRV;
        e.pos = pos_n;
        e.oh  = 1 << pos_n;
        e.es  = es_n;
        e.off = off_n;
        e.mov = (off_n != tgt_n) ? 1 : 0;
        e.dn  = (pos_n == NP - 1 && off_n == tgt_n) ? 1 : 0;
        exp_q.push_back(e);

        @(posedge Clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            got = exp_q.pop_front();
            $display("[TB] t=%0t tick=%0d L=%0d R=%0d pos=%0d off=%0d es=%0d",
                     $time, tick, pl, pr, lever_pos, plat_offset, end_stop);
            chk("lever_pos",    int'(lever_pos),    got.pos);
            chk("lever_onehot", int'(lever_onehot), got.oh);
            chk("end_stop",     int'(end_stop),     got.es);
            chk("plat_offset",  int'(plat_offset),  got.off);
            chk("plat_moving",  int'(plat_moving),  got.mov);
            chk("plat_down",    int'(plat_down),    got.dn);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pos"},    int'(lever_pos),    0);
        chk({tag, "_onehot"}, int'(lever_onehot), 1);
        chk({tag, "_es"},     int'(end_stop),     0);
        chk({tag, "_off"},    int'(plat_offset),  0);
        chk({tag, "_mov"},    int'(plat_moving),  0);
        chk({tag, "_down"},   int'(plat_down),    0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        Reset        = 1'b1;
        frame_tick   = 1'b0;
        push_left    = '0;
        push_right   = '0;
        model_reset();

        repeat (2) @(posedge Clk);
        #1;
        chk_reset_vals("reset");
        Reset = 1'b0;

        // Single held left press: exactly one step
        repeat (3) cycle(0, 1, 0);
        chk("left_onehot", int'(lever_onehot), 3'b010);
        cycle(0, 0, 0);
        chk("left_once_pos", int'(lever_pos), 1);

        // Right press during cooldown is ignored
        repeat (2) cycle(1, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        chk("right_in_cd", int'(lever_pos), 1);
        repeat (6) cycle(1, 0, 0);
        cycle(0, 0, 1);
        chk("right_after_cd", int'(lever_pos), 0);
        cycle(0, 0, 0);

        // Simultaneous left/right cancel, no cooldown load
        repeat (8) cycle(1, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        repeat (8) cycle(1, 0, 0);
        cycle(0, 1, 2);
        chk("cancel_pos", int'(lever_pos), 1);
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        chk("no_cd_after_cancel", int'(lever_pos), 2);
        cycle(0, 0, 0);

        // End stop at the leftmost position
        repeat (3) cycle(0, 2, 0);
        chk("end_stop_held", int'(end_stop), 2'b10);
        chk("end_stop_pos", int'(lever_pos), 2);
        cycle(0, 0, 0);
        chk("end_stop_clear", int'(end_stop), 0);

        // Platform travel to full depth
        repeat (60) cycle(1, 0, 0);
        chk("plat_full", int'(plat_offset), 48);
        chk("plat_down_full", int'(plat_down), 1);

        // Reset mid-travel and mid-cooldown
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        repeat (3) cycle(1, 0, 0);
        chk("pre_reset_off", int'(plat_offset), 45);
        #3;
        Reset = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        exp_q.delete();
        cycle(0, 1, 0);
        chk("push_after_reset", int'(lever_pos), 1);
        cycle(0, 0, 0);

        // Random traffic checked against the reference model
        for (int n = 0; n < 120; n++) begin
            cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
